// File: rtl/zx_attr_video.sv
// rtl/zx_attr_video.sv - ZX Spectrum attribute display generator with VGA timing
//
// Purpose: generates VGA timing and shows the 256x192 Spectrum bitmap, pixel-doubled
//   and framed by a programmable border. Bitmap and attribute bytes are fetched from
//   the 6912-byte screen RAM one cell ahead of display.
// Ports:
//   clk          pixel clock
//   reset        synchronous, active-low reset
//   border_color {G,R,B} border colour, sampled at the start of each line
//   vid_addr     screen RAM byte address (registered)
//   vid_data     screen RAM read data, valid one clock after vid_addr
//   vga_r/g/b    4-bit colour channels, zero outside the active area
//   vga_hs/vs    active-low syncs
//   vga_de       display enable
//   frame_int    one-clock pulse per frame
module zx_attr_video #(
  parameter int HA = 640,
  parameter int HFP = 16,
  parameter int HS = 96,
  parameter int HBP = 48,
  parameter int VA = 480,
  parameter int VFP = 11,
  parameter int VS = 2,
  parameter int VBP = 31,
  parameter int HBORDER = 64,
  parameter int VBORDER = 48,
  parameter int FLASH_FRAMES = 16,
  parameter logic [3:0] LVL_NORM = 4'hA,
  parameter logic [3:0] LVL_BRIGHT = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  border_color,
  output logic [12:0] vid_addr,
  input  logic [7:0]  vid_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic        frame_int
);

  localparam logic [9:0] H_LAST  = 10'(HA + HFP + HS + HBP - 1);
  localparam logic [9:0] V_LAST  = 10'(VA + VFP + VS + VBP - 1);
  localparam logic [9:0] H_ACT   = 10'(HA);
  localparam logic [9:0] V_ACT   = 10'(VA);
  localparam logic [9:0] HS_BEG  = 10'(HA + HFP);
  localparam logic [9:0] HS_END  = 10'(HA + HFP + HS);
  localparam logic [9:0] VS_BEG  = 10'(VA + VFP);
  localparam logic [9:0] VS_END  = 10'(VA + VFP + VS);
  localparam logic [9:0] PX_BEG  = 10'(HBORDER);
  localparam logic [9:0] PX_END  = 10'(HA - HBORDER);
  localparam logic [9:0] PY_BEG  = 10'(VBORDER);
  localparam logic [9:0] PY_END  = 10'(VA - VBORDER);
  // Each cell is fetched during the 16 clocks before it is displayed.
  localparam logic [9:0] FX_BEG  = 10'(HBORDER - 16);
  localparam logic [9:0] FX_END  = 10'(HA - HBORDER - 16);
  localparam int         FW      = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(FLASH_FRAMES - 1);

  logic [9:0]    hc_q, hc_d, vc_q, vc_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          flash_q, flash_d;
  logic [12:0]   vid_addr_q, vid_addr_d;
  logic [7:0]    bitmap_q, bitmap_d, attr_buf_q, attr_buf_d;
  logic [7:0]    shift_q, shift_d, attr_q, attr_d;
  logic [2:0]    border_q, border_d;
  logic [3:0]    r_q, r_d, g_q, g_d, b_q, b_d;
  logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d, fint_q, fint_d;

  logic          cur_fetch, nxt_fetch, paper_px, pix_sel;
  logic [3:0]    cur_s, nxt_s, level;
  logic [4:0]    nxt_k;
  logic [7:0]    nxt_y;
  logic [2:0]    colour;

  always_comb begin
    hc_d = (hc_q == H_LAST) ? 10'd0 : hc_q + 10'd1;
    vc_d = vc_q;
    if (hc_q == H_LAST) vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;

    cur_fetch = (vc_q >= PY_BEG) && (vc_q < PY_END) && (hc_q >= FX_BEG) && (hc_q < FX_END);
    cur_s     = 4'(hc_q - FX_BEG);
    // The address register is loaded from the next position so that it is
    // already valid during s0/s2 of each fetch window.
    nxt_fetch = (vc_d >= PY_BEG) && (vc_d < PY_END) && (hc_d >= FX_BEG) && (hc_d < FX_END);
    nxt_s     = 4'(hc_d - FX_BEG);
    nxt_k     = 5'((hc_d - FX_BEG) >> 4);
    nxt_y     = 8'((vc_d - PY_BEG) >> 1);

    vid_addr_d = vid_addr_q;
    if (nxt_fetch && (nxt_s < 4'd2)) vid_addr_d = {nxt_y[7:6], nxt_y[2:0], nxt_y[5:3], nxt_k};
    else if (nxt_fetch && (nxt_s < 4'd4)) vid_addr_d = {3'b110, nxt_y[7:3], nxt_k};

    bitmap_d   = (cur_fetch && cur_s == 4'd1) ? vid_data : bitmap_q;
    attr_buf_d = (cur_fetch && cur_s == 4'd3) ? vid_data : attr_buf_q;
    attr_d     = attr_q;
    shift_d    = shift_q;
    if (cur_fetch && cur_s == 4'd15) begin
      shift_d = bitmap_q;
      attr_d  = attr_buf_q;
    end else if (hc_q[0] != PX_BEG[0]) begin
      // Each bitmap pixel lasts two clocks.
      shift_d = {shift_q[6:0], 1'b0};
    end

    // Border colour is taken live on the first clock of the line, then held.
    border_d = (hc_q == 10'd0) ? border_color : border_q;

    paper_px = (vc_q >= PY_BEG) && (vc_q < PY_END) && (hc_q >= PX_BEG) && (hc_q < PX_END);
    pix_sel  = shift_q[7] ^ (attr_q[7] & flash_q);
    colour   = (hc_q == 10'd0) ? border_color : border_q;
    level    = LVL_NORM;
    if (paper_px) begin
      colour = pix_sel ? attr_q[2:0] : attr_q[5:3];
      level  = attr_q[6] ? LVL_BRIGHT : LVL_NORM;
    end

    de_d   = (hc_q < H_ACT) && (vc_q < V_ACT);
    r_d    = (de_d && colour[1]) ? level : 4'h0;
    g_d    = (de_d && colour[2]) ? level : 4'h0;
    b_d    = (de_d && colour[0]) ? level : 4'h0;
    hs_d   = !((hc_q >= HS_BEG) && (hc_q < HS_END));
    vs_d   = !((vc_q >= VS_BEG) && (vc_q < VS_END));
    fint_d = (hc_q == 10'd0) && (vc_q == VS_BEG);

    fcnt_d  = fcnt_q;
    flash_d = flash_q;
    if (fint_d) begin
      if (fcnt_q == F_LAST) begin
        fcnt_d  = '0;
        flash_d = !flash_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hc_q <= '0;  vc_q <= '0;  fcnt_q <= '0;  flash_q <= 1'b0;
      vid_addr_q <= '0;  bitmap_q <= '0;  attr_buf_q <= '0;
      shift_q <= '0;  attr_q <= '0;  border_q <= '0;
      r_q <= '0;  g_q <= '0;  b_q <= '0;
      hs_q <= 1'b1;  vs_q <= 1'b1;  de_q <= 1'b0;  fint_q <= 1'b0;
    end else begin
      hc_q <= hc_d;  vc_q <= vc_d;  fcnt_q <= fcnt_d;  flash_q <= flash_d;
      vid_addr_q <= vid_addr_d;  bitmap_q <= bitmap_d;  attr_buf_q <= attr_buf_d;
      shift_q <= shift_d;  attr_q <= attr_d;  border_q <= border_d;
      r_q <= r_d;  g_q <= g_d;  b_q <= b_d;
      hs_q <= hs_d;  vs_q <= vs_d;  de_q <= de_d;  fint_q <= fint_d;
    end
  end

  assign vid_addr  = vid_addr_q;
  assign vga_r     = r_q;
  assign vga_g     = g_q;
  assign vga_b     = b_q;
  assign vga_hs    = hs_q;
  assign vga_vs    = vs_q;
  assign vga_de    = de_q;
  assign frame_int = fint_q;

endmodule

// File: tb/tb_zx_attr_video.sv
// tb/tb_zx_attr_video.sv - randomized self-checking bench for zx_attr_video
module tb_zx_attr_video;

  // Reduced geometry keeps several whole frames (and flash phases) short.
  localparam int HA = 96, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 40, VFP = 2, VS = 2, VBP = 2;
  localparam int HB = 16, VB = 8, FF = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAMES_A = 5;

  logic        clk;
  logic        reset;
  logic [2:0]  border_color;
  logic [12:0] vid_addr;
  logic [7:0]  vid_data;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_de, frame_int;

  logic [7:0]  ram [0:8191];

  int n_checks = 0;
  int n_errors = 0;
  int mhc, mvc, events, exp_addr;
  logic [2:0] line_b;
  bit counting;
  int fi_cnt, hs_low;

  zx_attr_video #(
    .HA(HA), .HFP(HFP), .HS(HS), .HBP(HBP),
    .VA(VA), .VFP(VFP), .VS(VS), .VBP(VBP),
    .HBORDER(HB), .VBORDER(VB), .FLASH_FRAMES(FF),
    .LVL_NORM(4'hA), .LVL_BRIGHT(4'hF)
  ) dut (
    .clk(clk), .reset(reset), .border_color(border_color),
    .vid_addr(vid_addr), .vid_data(vid_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de), .frame_int(frame_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Screen RAM with one clock of read latency.
  always @(posedge clk) vid_data <= ram[vid_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (next hc=%0d vc=%0d)", tag, got, exp, mhc, mvc);
    end
  endtask

  function automatic int zx_bitmap_addr(int y, int k);
    return (y / 64) * 2048 + (y % 8) * 256 + ((y / 8) % 8) * 32 + k;
  endfunction

  function automatic int zx_attr_addr(int y, int k);
    return 6144 + 32 * (y / 8) + k;
  endfunction

  // Expected {r,g,b,hs,vs,de,frame_int} one clock after the counters sit at (hc,vc).
  function automatic logic [15:0] exp_out(int hc, int vc, logic [2:0] bcol);
    int x, y, k, lvl, pix;
    logic [7:0] bm, at;
    logic [2:0] col;
    logic [3:0] r, g, b;
    logic hs, vs, de, fi;
    de  = (hc < HA) && (vc < VA);
    col = bcol;
    lvl = 10;
    if (hc >= HB && hc < HA - HB && vc >= VB && vc < VA - VB) begin
      x   = (hc - HB) / 2;
      y   = (vc - VB) / 2;
      k   = x / 8;
      bm  = ram[zx_bitmap_addr(y, k)];
      at  = ram[zx_attr_addr(y, k)];
      pix = (bm >> (7 - (x % 8))) & 1;
      if (at[7] && ((events / FF) % 2 == 1)) pix = 1 - pix;
      col = (pix == 1) ? at[2:0] : at[5:3];
      lvl = at[6] ? 15 : 10;
    end
    r  = (de && col[1]) ? 4'(lvl) : 4'h0;
    g  = (de && col[2]) ? 4'(lvl) : 4'h0;
    b  = (de && col[0]) ? 4'(lvl) : 4'h0;
    hs = !(hc >= HA + HFP && hc < HA + HFP + HS);
    vs = !(vc >= VA + VFP && vc < VA + VFP + VS);
    fi = (hc == 0) && (vc == VA + VFP);
    return {r, g, b, hs, vs, de, fi};
  endfunction

  // Address the RAM should be seeing while the counters sit at (mhc,mvc).
  task automatic update_addr();
    int off, y;
    if (mvc >= VB && mvc < VA - VB && mhc >= HB - 16 && mhc < HA - HB - 16) begin
      off = mhc - (HB - 16);
      y   = (mvc - VB) / 2;
      if (off % 16 < 2)      exp_addr = zx_bitmap_addr(y, off / 16);
      else if (off % 16 < 4) exp_addr = zx_attr_addr(y, off / 16);
    end
  endtask

  task automatic tick();
    logic [15:0] e, got;
    bit rs;
    rs = (reset == 1'b0);
    if (rs) begin
      e = 16'h000C;
      mhc = 0; mvc = 0; events = 0; exp_addr = 0;
    end else begin
      if (mhc == 0) line_b = border_color;
      e = exp_out(mhc, mvc, line_b);
      if (mhc == 0 && mvc == VA + VFP) events++;
      mhc++;
      if (mhc == HT) begin
        mhc = 0;
        mvc++;
        if (mvc == VT) mvc = 0;
      end
      update_addr();
    end
    @(negedge clk);
    got = {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, frame_int};
    check_eq(rs ? "reset_state" : "video", 32'(got), 32'(e));
    check_eq("vid_addr", 32'(vid_addr), 32'(exp_addr));
    if (counting) begin
      fi_cnt += int'(frame_int);
      hs_low += int'(!vga_hs);
    end
    if ($urandom_range(0, 47) == 0) border_color = 3'($urandom_range(0, 7));
  endtask

  initial begin
    reset = 1'b0;
    border_color = 3'b100;
    vid_data = 8'h00;
    mhc = 0; mvc = 0; events = 0; exp_addr = 0; line_b = 3'b000;
    counting = 0; fi_cnt = 0; hs_low = 0;
    for (int i = 0; i < 8192; i++) ram[i] = 8'($urandom);
    ram[0]      = 8'h80;  // cell 0: one ink pixel, bright white ink on black
    ram[13'h1800] = 8'h47;
    ram[1]      = 8'hFF;  // cell 1: all ink, flashing red ink on blue paper
    ram[13'h1801] = 8'h8A;

    @(negedge clk);
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;

    counting = 1;
    for (int i = 0; i < FRAMES_A * HT * VT && n_errors < 50; i++) tick();
    counting = 0;
    check_eq("frame_int_count", 32'(fi_cnt), 32'(FRAMES_A));
    check_eq("hs_low_clocks", 32'(hs_low), 32'(FRAMES_A * VT * HS));

    // Reset in the middle of a paper line, then let it run from the top again.
    for (int i = 0; i < HT * VT && n_errors < 50 && !(mvc == VB + 2 && mhc == HB + 10); i++) tick();
    check_eq("mid_line_point", 32'(mvc * 1000 + mhc), 32'((VB + 2) * 1000 + HB + 10));
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 2 * HT * VT && n_errors < 50; i++) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
